// File: rtl/riscv_fetch_queue_if.sv
// Instruction-cache request/response bus between the fetch queue (master) and the cache (slave).
interface riscv_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              instr_req;
    logic              instr_gnt;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_rvalid;
    logic [DATA_W-1:0] instr_rdata;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata
    );
endinterface

// File: rtl/riscv_fetch_queue.sv
// IF-stage prefetch queue: keeps up to MAX_OUTSTANDING cache requests in flight and buffers
// returned words with their PC. Define FETCH_QUEUE_PERF_EN to add the two performance counters.
module riscv_fetch_queue #(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [ADDR_W-1:0]   branch_addr_i,
    riscv_fetch_queue_if.master cache,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                busy_o
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]         perf_empty_cnt_o,
    output logic [31:0]         perf_flush_cnt_o
`endif
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int APTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SUM_W  = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic [OUT_W-1:0]  outstanding_q;
    logic [OUT_W-1:0]  discard_q;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [APTR_W-1:0] pc_rd_q, pc_wr_q;

    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [MAX_OUTSTANDING];

    logic [SUM_W-1:0]  occupancy;
    logic              below_max, has_room;
    logic              fetch_req, grant, rsp, push, drop, pop;

    function automatic logic [APTR_W-1:0] pc_ptr_inc(input logic [APTR_W-1:0] p);
        return (p == APTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + APTR_W'(1);
    endfunction

    // Reserving queue space for every in-flight request guarantees a push never meets a full queue.
    assign occupancy = SUM_W'(count_q) + SUM_W'(outstanding_q);
    assign below_max = outstanding_q < OUT_W'(MAX_OUTSTANDING);
    assign has_room  = occupancy < SUM_W'(FIFO_DEPTH);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d   = state_q;
        fetch_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (branch_i) state_d = RUN;
            end
            RUN: begin
                fetch_req = req_i && !branch_i && below_max && has_room;
                if (!branch_i && !req_i && outstanding_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A response with nothing outstanding is stale (e.g. crossed a reset) and is ignored.
    assign grant = fetch_req && cache.instr_gnt;
    assign rsp   = cache.instr_rvalid && (outstanding_q != '0);
    assign push  = rsp && (discard_q == '0) && !branch_i;
    assign drop  = rsp && !push;
    assign pop   = valid_o && ready_i && !branch_i;

    // NOTE: state registers use non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_addr_q  <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            pc_rd_q       <= '0;
            pc_wr_q       <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_q + OUT_W'(grant) - OUT_W'(rsp);
            if (branch_i) begin
                fetch_addr_q <= branch_addr_i & ~ADDR_W'(3);
                discard_q    <= outstanding_q - OUT_W'(rsp);
                count_q      <= '0;
                rd_ptr_q     <= '0;
                wr_ptr_q     <= '0;
                pc_rd_q      <= '0;
                pc_wr_q      <= '0;
            end else begin
                if (grant) begin
                    fetch_addr_q <= fetch_addr_q + ADDR_W'(4);
                    pc_wr_q      <= pc_ptr_inc(pc_wr_q);
                end
                if (rsp && discard_q != '0) discard_q <= discard_q - OUT_W'(1);
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    pc_rd_q  <= pc_ptr_inc(pc_rd_q);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push && !pop)      count_q <= count_q + CNT_W'(1);
                else if (pop && !push) count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // NOTE: storage arrays are not reset; pointers and count define which entries are live,
    // and the head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (grant) pc_mem[pc_wr_q] <= fetch_addr_q;
        if (push) begin
            data_mem[wr_ptr_q] <= cache.instr_rdata;
            addr_mem[wr_ptr_q] <= pc_mem[pc_rd_q];
        end
    end

    assign cache.instr_req  = fetch_req;
    assign cache.instr_addr = fetch_addr_q;
    assign valid_o          = (count_q != '0);
    assign rdata_o          = valid_o ? data_mem[rd_ptr_q] : '0;
    assign addr_o           = valid_o ? addr_mem[rd_ptr_q] : '0;
    assign busy_o           = fetch_req || (outstanding_q != '0);

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_empty_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_empty_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (state_q == RUN && !valid_o && req_i && perf_empty_q != '1)
                perf_empty_q <= perf_empty_q + 32'd1;
            if (drop && perf_flush_q != '1)
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_empty_cnt_o = perf_empty_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue with an in-order cache model of programmable latency.
module tb_riscv_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        branch;
    logic [31:0] branch_addr;
    logic        ready;
    logic        valid;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] addr;

    int tests = 0;
    int fails = 0;

    riscv_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_empty;
    logic [31:0] perf_flush;
`endif

    riscv_fetch_queue #(
        .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_i(req),
        .branch_i(branch),
        .branch_addr_i(branch_addr),
        .cache(bus),
        .valid_o(valid),
        .ready_i(ready),
        .rdata_o(rdata),
        .addr_o(addr),
        .busy_o(busy)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_empty_cnt_o(perf_empty),
        .perf_flush_cnt_o(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    // Cache model: always grants; answers in order, each no earlier than lat cycles after its grant.
    int          cyc = 0;
    int          lat = 1;
    int          gnt_cnt = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h1000) >> 2);
    endfunction

    assign bus.instr_gnt = 1'b1;

    always @(posedge clk) begin
        if (bus.instr_rvalid === 1'b1) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (bus.instr_req === 1'b1) begin
            pend_addr.push_back(bus.instr_addr);
            pend_due.push_back(cyc + lat);
            gnt_cnt++;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            bus.instr_rvalid = 1'b1;
            bus.instr_rdata  = exp_data(pend_addr[0]);
        end else begin
            bus.instr_rvalid = 1'b0;
            bus.instr_rdata  = '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Waits (bounded) for a valid head, checks it, then steps past the pop (ready must be 1).
    task automatic expect_pop(input string tag, input logic [31:0] ea);
        int n = 0;
        while (valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, valid, 1);
        check({tag, "_addr"}, addr, ea);
        check({tag, "_data"}, rdata, exp_data(ea));
        step();
    endtask

    task automatic go_idle();
        int n = 0;
        req    = 1'b0;
        branch = 1'b0;
        #1;
        while ((busy !== 1'b0 || pend_addr.size() != 0) && n < 40) begin
            step();
            n++;
        end
        check("idle_reached", 32'(n < 40), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g0;
        int          bad;
        logic        found;
        logic [31:0] first_addr, first_data;
`ifdef FETCH_QUEUE_PERF_EN
        logic [31:0] f0;
`endif

        rst = 1'b1; req = 1'b0; branch = 1'b0; branch_addr = '0; ready = 1'b0;
        step();
        step();
        check("rst_instr_req", bus.instr_req, 0);
        check("rst_instr_addr", bus.instr_addr, 32'h0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr", addr, 32'h0);
        rst = 1'b0;

        // Basic stream: branch at T, req+gnt at T+1, rvalid at T+2, valid at T+3.
        ready = 1'b1; req = 1'b1; branch = 1'b1; branch_addr = 32'h1000;
        #1 check("t1_branch_cycle_req", bus.instr_req, 0);
        step(); branch = 1'b0;
        #1 check("t1_req_t1", bus.instr_req, 1);
        check("t1_addr_t1", bus.instr_addr, 32'h1000);
        check("t1_busy_t1", busy, 1);
        check("t1_valid_t1", valid, 0);
        step();
        check("t1_addr_t2", bus.instr_addr, 32'h1004);
        check("t1_valid_t2", valid, 0);
        step();
        check("t1_valid_t3", valid, 1);
        check("t1_head_addr_t3", addr, 32'h1000);
        check("t1_head_data_t3", rdata, 32'hA0);
        step();
        check("t1_head_addr_t4", addr, 32'h1004);
        check("t1_head_data_t4", rdata, 32'hA1);
        step();
        check("t1_head_addr_t5", addr, 32'h1008);

        // Fill with ready low: exactly four grants, then requests stop.
        go_idle();
        ready = 1'b0; lat = 1; g0 = gnt_cnt;
        req = 1'b1; branch = 1'b1; branch_addr = 32'h1000;
        step(); branch = 1'b0;
        repeat (8) step();
        check("t2_grants", 32'(gnt_cnt - g0), 4);
        check("t2_req_stalled", bus.instr_req, 0);
        check("t2_valid", valid, 1);
        check("t2_head", addr, 32'h1000);
        ready = 1'b1;
        #1 check("t2_req_full", bus.instr_req, 0);
        step();
        check("t2_resume_req", bus.instr_req, 1);
        check("t2_resume_addr", bus.instr_addr, 32'h1010);
        check("t2_pop1", addr, 32'h1004);
        step();
        check("t2_pop2", addr, 32'h1008);
        step();
        check("t2_pop3", addr, 32'h100C);
        step();
        check("t2_pop4", addr, 32'h1010);
        check("t2_pop4_data", rdata, exp_data(32'h1010));

        // Flush with two requests in flight: both late responses are dropped.
        go_idle();
        lat = 3; ready = 1'b1;
`ifdef FETCH_QUEUE_PERF_EN
        f0 = perf_flush;
`endif
        req = 1'b1; branch = 1'b1; branch_addr = 32'h1000;
        step(); branch = 1'b0;
        #1 check("t3_req_a", bus.instr_addr, 32'h1000);
        step();
        check("t3_req_b", bus.instr_addr, 32'h1004);
        step();
        check("t3_max_outstanding", bus.instr_req, 0);
        branch = 1'b1; branch_addr = 32'h2002; lat = 1;
        #1 check("t3_busy_branch", busy, 1);
        step(); branch = 1'b0;
        bad = 0; found = 1'b0; first_addr = '0; first_data = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid === 1'b1) begin
                if (!found) begin
                    found      = 1'b1;
                    first_addr = addr;
                    first_data = rdata;
                end
                if (addr[31:8] == 24'h000010) bad++;
            end
        end
        check("t3_found", 32'(found), 1);
        check("t3_first_addr", first_addr, 32'h2000);
        check("t3_first_data", first_data, exp_data(32'h2000));
        check("t3_stale_seen", bad, 0);
`ifdef FETCH_QUEUE_PERF_EN
        check("t3_perf_flush", perf_flush - f0, 2);
`endif

        // Branch in the same cycle as a response: that response and the other in-flight one drop.
        go_idle();
        lat = 2; ready = 1'b1;
        req = 1'b1; branch = 1'b1; branch_addr = 32'h3000;
        step(); branch = 1'b0;
        step();
        step();
        branch = 1'b1; branch_addr = 32'h4000;
        #1 check("t4_branch_req", bus.instr_req, 0);
        step(); branch = 1'b0;
        expect_pop("t4_pop0", 32'h4000);
        expect_pop("t4_pop1", 32'h4004);
        expect_pop("t4_pop2", 32'h4008);

        // req falls with one outstanding: response still lands, busy falls, state goes idle.
        go_idle();
        lat = 2; ready = 1'b0;
        req = 1'b1; branch = 1'b1; branch_addr = 32'h5000;
        step(); branch = 1'b0;
        #1 check("t5_req", bus.instr_req, 1);
        step(); req = 1'b0;
        #1 check("t5_req_off", bus.instr_req, 0);
        check("t5_busy_inflight", busy, 1);
        step();
        check("t5_busy_rvalid", busy, 1);
        check("t5_valid_rvalid", valid, 0);
        step();
        check("t5_busy_after", busy, 0);
        check("t5_valid_after", valid, 1);
        check("t5_head", addr, 32'h5000);
        check("t5_head_data", rdata, exp_data(32'h5000));
        step(); req = 1'b1;
        #1 check("t5_idle_no_req", bus.instr_req, 0);
        check("t5_idle_busy", busy, 0);

        // Address wrap at the top of the address space.
        go_idle();
        lat = 1; ready = 1'b1;
        req = 1'b1; branch = 1'b1; branch_addr = 32'hFFFF_FFF8;
        step(); branch = 1'b0;
        #1 check("t6_addr0", bus.instr_addr, 32'hFFFF_FFF8);
        step();
        check("t6_addr1", bus.instr_addr, 32'hFFFF_FFFC);
        step();
        check("t6_addr_wrap", bus.instr_addr, 32'h0000_0000);
        expect_pop("t6_pop0", 32'hFFFF_FFF8);
        expect_pop("t6_pop1", 32'hFFFF_FFFC);
        expect_pop("t6_pop2", 32'h0000_0000);

        // Reset mid-transaction: late responses are ignored, normal operation resumes.
        go_idle();
        lat = 3; ready = 1'b1;
        req = 1'b1; branch = 1'b1; branch_addr = 32'h6000;
        step(); branch = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        #1 check("t7_req_after_rst", bus.instr_req, 0);
        check("t7_busy_after_rst", busy, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t7_late_valid", valid, 0);
            check("t7_late_busy", busy, 0);
        end
        go_idle();
        lat = 1;
        req = 1'b1; branch = 1'b1; branch_addr = 32'h7000;
        step(); branch = 1'b0;
        expect_pop("t7_pop0", 32'h7000);
        expect_pop("t7_pop1", 32'h7004);
        go_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
